mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / restoring divide unit feeding HI/LO from the EX stage.
// Optional macro MULT_DIV_FAST_MULT_EN: MULT/MULTU finish in one cycle; divide is unchanged.
module mult_div_unit #(
    parameter int ITER_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    input  logic        stall,
    output logic        done,
    output logic [63:0] result
);

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_hi_q, neg_hi_d;
    logic        neg_lo_q, neg_lo_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] result_q, result_d;

    logic        is_start;
    logic        is_signed;
    logic        is_div_fn;
    logic        sign_1;
    logic        sign_2;
    logic [31:0] abs_1;
    logic [31:0] abs_2;

    logic [32:0] mul_sum;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] step_prod;
    logic [63:0] mul_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [63:0] final_result;

`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] ext_1;
    logic [63:0] ext_2;
    logic [63:0] fast_prod;
`endif

    assign is_start  = (funct == FN_MULT) || (funct == FN_MULTU) ||
                       (funct == FN_DIV)  || (funct == FN_DIVU);
    assign is_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign is_div_fn = funct[1];
    assign sign_1    = is_signed & operand_1[31];
    assign sign_2    = is_signed & operand_2[31];
    assign abs_1     = sign_1 ? (32'd0 - operand_1) : operand_1;
    assign abs_2     = sign_2 ? (32'd0 - operand_2) : operand_2;

`ifdef MULT_DIV_FAST_MULT_EN
    // Low 64 bits of a product of sign/zero-extended operands are the exact result.
    assign ext_1     = is_signed ? {{32{operand_1[31]}}, operand_1} : {32'd0, operand_1};
    assign ext_2     = is_signed ? {{32{operand_2[31]}}, operand_2} : {32'd0, operand_2};
    assign fast_prod = ext_1 * ext_2;
`endif

    // Multiply step: hi accumulates, lo shifts the multiplier out as product bits shift in.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, divisor_q} : 33'd0);
    assign mul_hi  = mul_sum[32:1];
    assign mul_lo  = {mul_sum[0], lo_q[31:1]};

    // Divide step: hi is the partial remainder, lo shifts the dividend out and quotient in.
    // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    assign rem_shift = {hi_q, lo_q[31]};
    assign trial     = rem_shift - {1'b0, divisor_q};
    assign trial_ge  = (rem_shift >= {1'b0, divisor_q});
    assign div_hi    = trial_ge ? trial[31:0] : rem_shift[31:0];
    assign div_lo    = {lo_q[30:0], trial_ge};

    assign step_hi      = is_div_q ? div_hi : mul_hi;
    assign step_lo      = is_div_q ? div_lo : mul_lo;
    assign step_prod    = {step_hi, step_lo};
    assign mul_fixed    = neg_lo_q ? (64'd0 - step_prod) : step_prod;
    assign quo_fixed    = neg_lo_q ? (32'd0 - step_lo) : step_lo;
    assign rem_fixed    = neg_hi_q ? (32'd0 - step_hi) : step_hi;
    assign final_result = is_div_q ? {rem_fixed, quo_fixed} : mul_fixed;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_hi_d  = neg_hi_q;
        neg_lo_d  = neg_lo_q;
        divisor_d = divisor_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_start) begin
`ifdef MULT_DIV_FAST_MULT_EN
                        if (!is_div_fn) begin
                            result_d = fast_prod;
                            state_d  = S_DONE;
                        end else
`endif
                        begin
                            is_div_d  = is_div_fn;
                            divisor_d = is_div_fn ? abs_2 : abs_1;
                            lo_d      = is_div_fn ? abs_1 : abs_2;
                            hi_d      = 32'd0;
                            // Quotient keeps its all-ones pattern on divide by zero.
                            neg_lo_d  = (sign_1 ^ sign_2) & ~(is_div_fn & (operand_2 == 32'd0));
                            neg_hi_d  = is_div_fn ? sign_1 : (sign_1 ^ sign_2);
                            cnt_d     = 5'd0;
                            state_d   = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        result_d = final_result;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            divisor_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_hi_q  <= neg_hi_d;
            neg_lo_q  <= neg_lo_d;
            divisor_q <= divisor_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  funct = 6'h00;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    int tick = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    mult_div_unit #(.ITER_COUNT(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .funct     (funct),
        .operand_1 (op1),
        .operand_2 (op2),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    // Reference: plain language arithmetic, with the unit's divide-by-zero rule.
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (fn == FN_MULT) return 64'(sa * sb);
        if (fn == FN_MULTU) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (fn == FN_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int t0);
        @(posedge clk); #1;
        funct = fn; op1 = a; op2 = b;
        t0 = tick;
        @(negedge clk);
        chk("no_done_at_start", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        funct = 6'h00; op1 = $urandom; op2 = $urandom;
    endtask

    task automatic wait_done(input int t0, input int exp_lat, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        chk({tag, "_latency"}, 64'(tick - t0), 64'(exp_lat));
    endtask

    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int t0;
        start_op(fn, a, b, t0);
        wait_done(t0, fn[1] ? DIV_LAT : MUL_LAT, tag);
        chk({tag, "_result"}, result, exp);
        $display("op %s funct=%h a=%h b=%h result=%h", tag, fn, a, b, result);
        @(negedge clk);
        chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int t0;
        logic seen_done;
        logic [5:0] fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0] fn_tab [4];

        fn_tab[0] = FN_MULT; fn_tab[1] = FN_MULTU; fn_tab[2] = FN_DIV; fn_tab[3] = FN_DIVU;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst_n = 1'b1;

        run_op(FN_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(FN_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100_7");
        run_op(FN_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        run_op(FN_DIV,   32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, "div_by_zero");
        run_op(FN_DIVU,  32'h8765_4321, 32'd0,         64'h8765_4321_FFFF_FFFF, "divu_by_zero");
        run_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow");

        // Stall hold in DONE
        start_op(FN_DIVU, 32'd1000, 32'd33, t0);
        wait_done(t0, DIV_LAT, "stall");
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_done", {63'd0, done}, 64'd1);
            chk("stall_hold_result", result, 64'h0000_000A_0000_001E);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release", {63'd0, done}, 64'd0);
        $display("op stall_hold result=%h", result);

        // Flush at cycle 10 aborts; result keeps the previous value
        start_op(FN_DIVU, 32'hDEAD_BEEF, 32'd3, t0);
        while (tick - t0 < 10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("flush_no_done", {63'd0, seen_done}, 64'd0);
        chk("flush_result_kept", result, 64'h0000_000A_0000_001E);
        $display("op flush_abort result=%h", result);
        run_op(FN_DIVU, 32'd9, 32'd3, 64'h0000_0000_0000_0003, "divu_after_flush");

        // Asynchronous reset at cycle 10
        start_op(FN_DIVU, 32'd12345, 32'd17, t0);
        while (tick - t0 < 10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", {63'd0, done}, 64'd0);
        $display("op async_reset result=%h", result);

        // Back-to-back: funct stays MULT; operands changed mid-op are picked up by the second
        @(posedge clk); #1;
        funct = FN_MULT; op1 = 32'hFFFF_FFFD; op2 = 32'h0000_0007;
        t0 = tick;
        @(posedge clk); #1;
        op1 = 32'h0001_0000; op2 = 32'h0001_0000;
        wait_done(t0, MUL_LAT, "b2b_first");
        chk("b2b_first_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        $display("op b2b_first result=%h", result);
        @(negedge clk);
        chk("b2b_gap", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        funct = 6'h00;
        wait_done(t0, 2 * MUL_LAT + 1, "b2b_second");
        chk("b2b_second_result", result, 64'h0000_0001_0000_0000);
        $display("op b2b_second result=%h", result);
        @(negedge clk);
        chk("b2b_second_drop", {63'd0, done}, 64'd0);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            fn = fn_tab[$urandom_range(3, 0)];
            a  = $urandom;
            case ($urandom_range(3, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15, 1));
                2: b = 32'd0 - 32'($urandom_range(15, 1));
                default: b = $urandom;
            endcase
            run_op(fn, a, b, model(fn, a, b), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
